hact_acc_sched: RTL
===================

# hact_acc_sched

Accumulation scheduler that sequences the hardware activation array in the stochastic-computing uBrain datapath. It collects ADIM beats of per-lane partial counts from the upstream multiply/count stage and sums each lane into an offset-binary accumulation. It presents each finished group to the activation array through a one-deep output register with valid/ready handshake. It also tracks the number of groups in a layer and flags the last group and layer completion.

## Interface
- IDIM, 4, number of parallel lanes (matches activation array width)
- BWID, 8, width of one beat per lane (unsigned count, 0..2^BWID-1)
- ADIM, 32, beats accumulated per group
- IWID, 16, accumulator/output width per lane; must be >= BWID + clog2(ADIM)
- GWID, 16, width of group count
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- iStart  in  1  layer start pulse, honoured only in IDLE
- iGrpNum  in  GWID  groups in layer, latched on accepted iStart
- iValid  in  1  input beat valid
- iReady  out  1  input beat accepted when iValid && iReady
- iData  in  BWID x IDIM  per-lane beat value
- oValid  out  1  output group valid
- oReady  in  1  activation side accepts when oValid && oReady
- oData  out  IWID x IDIM  per-lane accumulated sum (zero point ADIM*2^BWID/2)
- oLast  out  1  qualifies oData as final group of layer
- oBusy  out  1  state != IDLE
- oDone  out  1  one-cycle layer-complete pulse

## Operation
- States: IDLE, ACC, DRAIN.
- IDLE: iReady=0. If iStart && iGrpNum!=0, latch grpTot=iGrpNum, clear beatCnt and grpCnt, go ACC. If iStart && iGrpNum==0, pulse oDone next cycle and stay IDLE.
- ACC: each accepted beat updates per-lane acc. Beat 0 loads acc = zero-extended iData. Other beats do acc += iData, modulo 2^IWID. beatCnt then increments.
- Last beat (beatCnt==ADIM-1) is accepted only if the output register is empty or is being drained this cycle. So iReady = (state==ACC) && !(beatCnt==ADIM-1 && oValid && !oReady).
- On accepted last beat:
  - oData <= acc + iData.
  - oValid <= 1.
  - oLast <= (grpCnt==grpTot-1).
  - beatCnt <= 0 and grpCnt++.
  - If that was the final group, go DRAIN; else stay ACC.
- Accumulation of the next group proceeds while the previous group waits in the output register; stalling happens only on its last beat.
- DRAIN: iReady=0. On the oValid && oReady handshake, go IDLE and pulse oDone the following cycle.
- Output register: oValid clears on handshake unless reloaded in the same cycle, in which case the new group replaces it and oValid stays 1.
- oData/oLast are held stable while oValid && !oReady.
- iStart outside IDLE is ignored. iData is ignored when !iValid or !iReady.

## Timing
- Reset (rst_n=0 at clk edge): state IDLE, counters 0, acc 0, oData 0, oValid/oLast/oBusy/oDone/iReady 0.
- Reset mid-operation discards partial accumulation and any pending output, with no oDone.
- iStart accepted at edge N: oBusy=1 and iReady=1 from cycle N+1.
- Latency: last beat accepted at edge N -> oValid=1 with sum during cycle N+1.
- Throughput with oReady held 1: one beat per cycle, no bubble between groups. A layer of G groups takes G*ADIM beat cycles, +1 cycle to oValid, +1 cycle to oDone.
- Final handshake at edge M: oBusy=0 and oDone=1 in cycle M+1 only.
- No overflow detection: sums wrap modulo 2^IWID, which is unreachable when the width rule holds.

## Test plan
- Single group, defaults, iGrpNum=1, 32 beats all lanes = 128 -> oData=4096 on every lane one cycle after beat 32, oLast=1, oReady=1 -> oDone pulse next cycle, oBusy=0.
- Max values: 32 beats of 255 -> oData=8160. 32 beats of 0 -> 0. Mixed per-lane 255/0/1/128 -> 8160/0/32/4096.
- Backpressure: iGrpNum=2, oReady=0 -> group 1 held. iReady drops at group 2 beat 31 until oReady=1. That cycle sees group 1 handshake plus group 2 load, and oValid stays 1 with oLast=1.
- Gapped input: iValid toggling every other cycle -> same sums as continuous, beat count unaffected by idle cycles.
- iGrpNum=0 -> no iReady, oDone pulses one cycle after iStart. iStart during ACC is ignored (grpTot unchanged).
- rst_n low at group 1 beat 17 -> all outputs 0 next cycle, no oDone. A new iStart then produces correct sums from scratch.

Source files
------------

// File: rtl/hact_acc_sched.sv
// Accumulation scheduler for the activation array: sums ADIM beats per lane into one group,
// hands groups out through a one-deep valid/ready register and tracks groups per layer.
module hact_acc_sched #(
    parameter int unsigned IDIM = 4,
    parameter int unsigned BWID = 8,
    parameter int unsigned ADIM = 32,
    parameter int unsigned IWID = 16,
    parameter int unsigned GWID = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   iStart,
    input  logic [GWID-1:0]        iGrpNum,
    input  logic                   iValid,
    output logic                   iReady,
    input  logic [BWID*IDIM-1:0]   iData,
    output logic                   oValid,
    input  logic                   oReady,
    output logic [IWID*IDIM-1:0]   oData,
    output logic                   oLast,
    output logic                   oBusy,
    output logic                   oDone
);

    localparam int unsigned BCW = (ADIM > 1) ? $clog2(ADIM) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN} state_t;

    state_t                     state_q, state_d;
    logic [BCW-1:0]             beat_cnt_q, beat_cnt_d;
    logic [GWID-1:0]            grp_cnt_q, grp_cnt_d;
    logic [GWID-1:0]            grp_tot_q, grp_tot_d;
    logic [IDIM-1:0][IWID-1:0]  acc_q, acc_d;
    logic [IDIM-1:0][IWID-1:0]  odata_q, odata_d;
    logic                       ovalid_q, ovalid_d;
    logic                       olast_q, olast_d;
    logic                       done_q, done_d;
    logic [IDIM-1:0][IWID-1:0]  lane_sum;

    logic last_beat, final_grp, in_fire, out_fire;

    assign last_beat = (beat_cnt_q == BCW'(ADIM - 1));
    assign final_grp = (grp_cnt_q == grp_tot_q - GWID'(1));
    // The last beat stalls only when it would overwrite an output nobody is taking.
    assign iReady    = (state_q == S_ACC) && !(last_beat && ovalid_q && !oReady);
    assign in_fire   = iValid && iReady;
    assign out_fire  = ovalid_q && oReady;

    assign oValid = ovalid_q;
    assign oData  = odata_q;
    assign oLast  = olast_q;
    assign oBusy  = (state_q != S_IDLE);
    assign oDone  = done_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (iStart && (iGrpNum != GWID'(0))) state_d = S_ACC;
            S_ACC:   if (in_fire && last_beat && final_grp) state_d = S_DRAIN;
            S_DRAIN: if (out_fire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Beat 0 restarts the lane sum; later beats add onto it.
    always_comb begin
        lane_sum = '0;
        for (int unsigned l = 0; l < IDIM; l++) begin
            lane_sum[l] = ((beat_cnt_q == BCW'(0)) ? IWID'(0) : acc_q[l])
                        + IWID'(iData[l*BWID +: BWID]);
        end
    end

    // Counters, accumulator and output register
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        grp_cnt_d  = grp_cnt_q;
        grp_tot_d  = grp_tot_q;
        acc_d      = acc_q;
        odata_d    = odata_q;
        olast_d    = olast_q;
        ovalid_d   = ovalid_q && !oReady;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    if (iGrpNum != GWID'(0)) begin
                        grp_tot_d  = iGrpNum;
                        beat_cnt_d = '0;
                        grp_cnt_d  = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_ACC: begin
                if (in_fire) begin
                    acc_d = lane_sum;
                    if (last_beat) begin
                        odata_d    = lane_sum;
                        ovalid_d   = 1'b1;
                        olast_d    = final_grp;
                        beat_cnt_d = '0;
                        grp_cnt_d  = grp_cnt_q + GWID'(1);
                    end else begin
                        beat_cnt_d = beat_cnt_q + BCW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (out_fire) done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            grp_cnt_q  <= '0;
            grp_tot_q  <= '0;
            acc_q      <= '0;
            odata_q    <= '0;
            ovalid_q   <= 1'b0;
            olast_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            grp_cnt_q  <= grp_cnt_d;
            grp_tot_q  <= grp_tot_d;
            acc_q      <= acc_d;
            odata_q    <= odata_d;
            ovalid_q   <= ovalid_d;
            olast_q    <= olast_d;
            done_q     <= done_d;
        end
    end

endmodule
